// File: rtl/comparators_pkg.sv
// Shared constants and FSM state type for the comparator group's streaming blocks.
package comparators_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int DEFAULT_IDX_W = 8;

    typedef enum logic {
        START,
        ACCUM
    } state_t;

endpackage

// File: rtl/argmin_cell.sv
// Combinational compare-and-select: keeps the held minimum unless the new sample is strictly smaller.
module argmin_cell
    import comparators_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic [WIDTH-1:0] cur_min,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic [WIDTH-1:0] in_data,
    input  logic [IDX_W-1:0] pos,
    output logic [WIDTH-1:0] next_min,
    output logic [IDX_W-1:0] next_idx
);

    logic take;

    // Strict less-than so that ties keep the earlier index.
    assign take     = in_data < cur_min;
    assign next_min = take ? in_data : cur_min;
    assign next_idx = take ? pos : cur_idx;

endmodule

// File: rtl/stream_argmin.sv
// Streaming per-frame minimum/argmin tracker with a single-entry valid/ready result register.
module stream_argmin
    import comparators_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_ovf
);

    localparam logic [IDX_W-1:0] POS_MAX = {IDX_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_min_q, cur_min_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic [WIDTH-1:0] cell_min;
    logic [IDX_W-1:0] cell_idx;

    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    argmin_cell #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_cell (
        .cur_min  (cur_min_q),
        .cur_idx  (cur_idx_q),
        .in_data  (in_data),
        .pos      (pos_q),
        .next_min (cell_min),
        .next_idx (cell_idx)
    );

    // full_q marks that index POS_MAX has been used, so only a sample beyond it flags overflow.
    always_comb begin
        state_d     = state_q;
        cur_min_d   = cur_min_q;
        cur_idx_d   = cur_idx_q;
        pos_d       = pos_q;
        full_d      = full_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_min_d   = out_min_q;
        out_idx_d   = out_idx_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            if (state_q == START) begin
                cur_min_d = in_data;
                cur_idx_d = '0;
                pos_d     = IDX_W'(1);
                full_d    = 1'b0;
                ovf_d     = 1'b0;
                state_d   = ACCUM;
            end else begin
                cur_min_d = cell_min;
                cur_idx_d = cell_idx;
                if (pos_q == POS_MAX) begin
                    full_d = 1'b1;
                    ovf_d  = ovf_q | full_q;
                end else begin
                    pos_d = pos_q + IDX_W'(1);
                end
            end
        end

        // The published result already includes the sample accepted this cycle.
        if (accept && in_last) begin
            out_valid_d = 1'b1;
            out_min_d   = cur_min_d;
            out_idx_d   = cur_idx_d;
            out_ovf_d   = ovf_d;
            state_d     = START;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= START;
            cur_min_q   <= '0;
            cur_idx_q   <= '0;
            pos_q       <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_idx_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_min_q   <= cur_min_d;
            cur_idx_q   <= cur_idx_d;
            pos_q       <= pos_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_min_q   <= out_min_d;
            out_idx_q   <= out_idx_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_min   = out_min_q;
    assign out_idx   = out_idx_q;
    assign out_ovf   = out_ovf_q;

endmodule
